dunit_inst_loader: RTL
======================

# dunit_inst_loader

Debug-unit instruction loader that sits directly upstream of the IF stage. It receives program bytes from the UART receiver and assembles them into 32-bit MIPS instructions. It writes those instructions sequentially into the IF instruction memory through the IF debug port (`dunit_w_en` / `dunit_addr` / `dunit_data`), and holds the pipeline clock-enable low while loading. Loading ends on the HALT word or when memory is full.

## Interface
- `NB_REG`, 32: instruction/data word width.
- `NB_WIDHT`, 9: instruction-memory byte-address width (512 bytes = 128 words).
- `NB_BYTE`, 8: UART byte width.
- `HALT_INST`, 32'hFFFF_FFFF: end-of-program marker.

Ports:
- `i_clk`  in  1  system clock; single clock domain.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_load_start`  in  1  one-cycle pulse; starts a load at address 0.
- `i_rx_data`  in  NB_BYTE  byte from UART rx.
- `i_rx_valid`  in  1  one-cycle strobe; `i_rx_data` is valid.
- `o_dunit_w_en`  out  1  IF instruction-memory write enable (one-cycle pulse per word).
- `o_dunit_addr`  out  NB_WIDHT  IF byte address of the word being written.
- `o_dunit_data`  out  NB_REG  assembled instruction.
- `o_dunit_clk_en`  out  1  pipeline clock enable; 0 while loading.
- `o_busy`  out  1  load in progress.
- `o_load_done`  out  1  level; load finished.
- `o_overflow`  out  1  level; memory filled without a HALT.
- `o_inst_count`  out  NB_WIDHT-1  number of words written, HALT included.

## Operation
- States: IDLE, RECV, WRITE, DONE.
- IDLE:
  - Outputs are at their reset values.
  - On `i_load_start`: clear the byte counter, address, count, `o_load_done` and `o_overflow`; go to RECV.
- RECV:
  - Each `i_rx_valid` shifts the byte in, big-endian: the first byte becomes bits [31:24].
  - The byte counter runs 0..3. On the 4th byte, go to WRITE.
- WRITE (exactly one cycle):
  - `o_dunit_w_en`=1 with the current `o_dunit_addr` and `o_dunit_data`.
  - `o_inst_count` +1.
  - If the word equals `HALT_INST`: go to DONE.
  - Else if `o_dunit_addr` == 2^NB_WIDHT−4: go to DONE and set `o_overflow`=1.
  - Else: `o_dunit_addr` += 4 and return to RECV.
  - An `i_rx_valid` arriving in the WRITE cycle is not dropped; it is captured as byte 0 of the next word (byte counter = 1 on return to RECV).
- DONE:
  - `o_load_done`=1, `o_busy`=0, `o_dunit_clk_en`=1.
  - `o_dunit_addr`, `o_inst_count` and `o_overflow` hold their values.
  - `i_rx_valid` is ignored.
  - `i_load_start` restarts the load exactly as from IDLE.
- `i_load_start` in RECV or WRITE is ignored.
- `o_busy` = (state ∈ {RECV, WRITE}).
- `o_dunit_clk_en` = !`o_busy`.
- Address arithmetic is modulo 2^NB_WIDHT. It never actually wraps, because of the overflow stop.

## Timing
- Reset values: state=IDLE, `o_dunit_w_en`=0, `o_dunit_addr`=0, `o_dunit_data`=0, `o_dunit_clk_en`=1, `o_busy`=0, `o_load_done`=0, `o_overflow`=0, `o_inst_count`=0, byte counter=0.
- Reset mid-load: everything returns to the reset values on the next edge; a partial word is discarded and no write is issued.
- Start pulse at edge N: `o_busy`=1 and `o_dunit_clk_en`=0 from N+1.
- 4th `i_rx_valid` sampled at edge N: `o_dunit_w_en`=1 during cycle N+1, i.e. 1-cycle latency.
- `o_dunit_addr` and `o_dunit_data` are registered and stable for the whole write cycle.
- `o_load_done` rises on the edge that ends the final WRITE cycle.
- Bytes may arrive back-to-back, one per cycle, with no loss.

## Structure
- Shared package/header `mips_dunit_pkg`:
  - `HALT_INST`.
  - State encodings (IDLE=2'd0, RECV=2'd1, WRITE=2'd2, DONE=2'd3).
  - `NB_BYTE`.
- Sub-module `dunit_word_assembler`:
  - Big-endian 4-byte shift register plus 2-bit byte counter.
  - Inputs: `i_clk`, `i_reset`, `i_clear`, `i_push`, `i_byte`.
  - Outputs: `o_word`, `o_word_valid` (one cycle).
- Top module holds the FSM, address counter, word counter and status flags.

## Test plan
- Load 3 words: send 8C01_0004, 0022_1820, FFFF_FFFF as 12 bytes MSB-first → exactly three write pulses at addr 0x000/0x004/0x008 with those values; `o_inst_count`=3; `o_load_done`=1; `o_overflow`=0; `o_dunit_clk_en` low from start through the last write.
- Back-to-back bytes: `i_rx_valid` held high for 8 cycles, including the WRITE cycle → 2 correct words, no byte lost or duplicated.
- Overflow: send 128 non-HALT words → the last write is at addr 0x1FC, then DONE with `o_overflow`=1 and `o_inst_count`=128; further bytes produce no writes.
- Reset mid-word: after 2 bytes, pulse `i_reset` → no write; all outputs at reset values; a subsequent full load starts at addr 0.
- `i_load_start` pulsed during RECV → ignored; the address sequence continues unchanged.
- Restart from DONE: `i_load_start` → flags cleared; the next word is written at addr 0x000.

Source files
------------

// File: rtl/mips_dunit_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mips_dunit_pkg: shared constants and state encoding for the loader |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
package mips_dunit_pkg;

  localparam int unsigned NB_BYTE = 8;
  localparam logic [31:0] HALT_INST = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } loader_state_e;

endpackage
`default_nettype wire

// File: rtl/dunit_word_assembler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dunit_word_assembler: big-endian byte-to-word packer              |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module dunit_word_assembler
  import mips_dunit_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_clear,
  input  logic                 i_push,
  input  logic [NB_BYTE-1:0]   i_byte,
  output logic [4*NB_BYTE-1:0] o_word,
  output logic                 o_word_valid
);

  logic [3*NB_BYTE-1:0] r_shift;
  logic [1:0]           r_byte_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_shift    <= '0;
      r_byte_cnt <= 2'd0;
    end else if (i_push) begin
      r_shift    <= {r_shift[2*NB_BYTE-1:0], i_byte};
      r_byte_cnt <= r_byte_cnt + 2'd1;
    end
  end

  // The 4th byte completes the word combinationally so the owner can register it on the same edge.
  assign o_word       = {r_shift, i_byte};
  assign o_word_valid = i_push && (r_byte_cnt == 2'd3);

endmodule
`default_nettype wire

// File: rtl/dunit_inst_loader.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dunit_inst_loader: UART bytes -> IF instruction memory writes      |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module dunit_inst_loader #(
  parameter int NB_REG   = 32,
  parameter int NB_WIDHT = 9
) (
  input  logic                                i_clk,
  input  logic                                i_reset,
  input  logic                                i_load_start,
  input  logic [mips_dunit_pkg::NB_BYTE-1:0]  i_rx_data,
  input  logic                                i_rx_valid,
  output logic                                o_dunit_w_en,
  output logic [NB_WIDHT-1:0]                 o_dunit_addr,
  output logic [NB_REG-1:0]                   o_dunit_data,
  output logic                                o_dunit_clk_en,
  output logic                                o_busy,
  output logic                                o_load_done,
  output logic                                o_overflow,
  output logic [NB_WIDHT-2:0]                 o_inst_count
);

  import mips_dunit_pkg::*;

  localparam logic [NB_WIDHT-1:0] c_last_addr = NB_WIDHT'((1 << NB_WIDHT) - 4);
  localparam logic [NB_WIDHT-1:0] c_addr_step = NB_WIDHT'(4);
  localparam logic [NB_WIDHT-2:0] c_cnt_one   = (NB_WIDHT-1)'(1);

  loader_state_e          r_state;
  logic                   r_w_en;
  logic [NB_WIDHT-1:0]    r_addr;
  logic [NB_REG-1:0]      r_data;
  logic                   r_clk_en;
  logic                   r_busy;
  logic                   r_load_done;
  logic                   r_overflow;
  logic [NB_WIDHT-2:0]    r_inst_count;

  logic                   w_start;
  logic                   w_push;
  logic [4*NB_BYTE-1:0]   w_word;
  logic                   w_word_valid;

  assign w_start = i_load_start && (r_state == ST_IDLE || r_state == ST_DONE);
  // Bytes landing in the WRITE cycle belong to the next word, so keep accepting them.
  assign w_push  = i_rx_valid && (r_state == ST_RECV || r_state == ST_WRITE);

  dunit_word_assembler u_assembler (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_clear      (w_start),
    .i_push       (w_push),
    .i_byte       (i_rx_data),
    .o_word       (w_word),
    .o_word_valid (w_word_valid)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_w_en       <= 1'b0;
      r_addr       <= '0;
      r_data       <= '0;
      r_clk_en     <= 1'b1;
      r_busy       <= 1'b0;
      r_load_done  <= 1'b0;
      r_overflow   <= 1'b0;
      r_inst_count <= '0;
    end else begin
      r_w_en <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_start) begin
            r_state      <= ST_RECV;
            r_addr       <= '0;
            r_inst_count <= '0;
            r_load_done  <= 1'b0;
            r_overflow   <= 1'b0;
            r_busy       <= 1'b1;
            r_clk_en     <= 1'b0;
          end
        end
        ST_RECV: begin
          if (w_word_valid) begin
            r_state <= ST_WRITE;
            r_w_en  <= 1'b1;
            r_data  <= w_word;
          end
        end
        ST_WRITE: begin
          r_inst_count <= r_inst_count + c_cnt_one;
          if (r_data == HALT_INST || r_addr == c_last_addr) begin
            r_state     <= ST_DONE;
            r_load_done <= 1'b1;
            r_busy      <= 1'b0;
            r_clk_en    <= 1'b1;
            r_overflow  <= (r_data != HALT_INST);
          end else begin
            r_state <= ST_RECV;
            r_addr  <= r_addr + c_addr_step;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_dunit_w_en   = r_w_en;
  assign o_dunit_addr   = r_addr;
  assign o_dunit_data   = r_data;
  assign o_dunit_clk_en = r_clk_en;
  assign o_busy         = r_busy;
  assign o_load_done    = r_load_done;
  assign o_overflow     = r_overflow;
  assign o_inst_count   = r_inst_count;

endmodule
`default_nettype wire
